mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM stage of the pipelined LC-3b: consumes the AGEX->MEM pipeline register (address, ALU result, IR, DRID, NPC, control).
//  Performs data-cache accesses (LDR/STR/LDB/STB/LDI/STI) over a request/response handshake, stalls the pipe while busy.
//  Forwards the result to the MEM->WB pipeline register.
//  LDI/STI are two-step: pointer read, then the final access.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles waiting on one dmem_resp before mem_error sets (0 = check disabled)
// PORTS
//  clk            in   1   rising-edge clock
//  reset_n        in   1   asynchronous, active-low reset
//  mem_valid      in   1   instruction in MEM register is valid
//  mem_read       in   1   instruction is a load (LDR/LDB/LDI)
//  mem_write      in   1   instruction is a store (STR/STB/STI)
//  mem_byte       in   1   byte access (LDB/STB)
//  mem_indirect   in   1   indirect access (LDI/STI)
//  mem_address    in   16  effective address from AGEX
//  mem_aluresult  in   16  ALU/shift result from AGEX
//  mem_srdata     in   16  store data (SR)
//  mem_ir/mem_npc in   16  IR / NPC passthrough
//  mem_drid       in   3   destination register id
//  dmem_rdata     in   16  cache read data
//  dmem_resp      in   1   cache response (1 cycle per access)
//  dmem_address   out  16  cache address
//  dmem_read      out  1   read request
//  dmem_write     out  1   write request
//  dmem_wmask     out  2   byte enables {hi,lo}
//  dmem_wdata     out  16  write data
//  stall_out      out  1   hold all upstream pipeline registers
//  wb_valid       out  1   MEM->WB entry valid
//  wb_data        out  16  load data or ALU result
//  wb_ir/wb_npc   out  16  passthrough
//  wb_drid        out  3   passthrough
//  mem_error      out  1   sticky: a wait exceeded WAIT_LIMIT
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - state=IDLE; ptr_reg, rdata_reg, wait_cnt=0; mem_error=0.
//   - dmem_read/write=0 immediately, even mid-access; any later dmem_resp is ignored.
//  States
//   - IDLE
//     - op = mem_valid & (mem_read|mem_write).
//     - op=0: wb_valid=mem_valid, wb_data=mem_aluresult, stall=0.
//     - op=1: stall=1, wb_valid=0; next = IND if mem_indirect else ACC.
//   - IND: dmem_read=1, dmem_address={mem_address[15:1],0}.
//     - On resp: ptr_reg<=dmem_rdata; next ACC. Stall=1.
//   - ACC: addr A = indirect ? ptr_reg : mem_address.
//     - Read or write by mem_read/mem_write. Stall=1.
//     - On resp: rdata_reg<=dmem_rdata; next DONE.
//   - DONE: stall=0, wb_valid=1; next IDLE; pipe advances at this edge.
//     - wb_data: word load = rdata_reg; byte load = zext(A[0] ? rdata_reg[15:8] : rdata_reg[7:0]); store = mem_aluresult.
//  Write rules
//   - Word: dmem_address={A[15:1],0}, wmask=11, wdata=mem_srdata.
//   - Byte: wmask = A[0] ? 10 : 01, wdata={srdata[7:0],srdata[7:0]}.
//  Handshake
//   - Request signals stay constant until the cycle dmem_resp=1 and drop the next cycle (state change).
//   - dmem_resp in IDLE/DONE is ignored.
//   - dmem_read and dmem_write are never both 1.
//   - Pointer read ignores mem_byte (always word).
//  Latency
//   - Non-memory instruction: 0 extra cycles.
//   - Direct access: resp-latency + 2 cycles of stall... DONE (stall low in DONE).
//   - Indirect access: two resp waits + DONE.
//  Timeout
//   - wait_cnt clears on state entry and increments each IND/ACC cycle without resp.
//   - If WAIT_LIMIT != 0 and wait_cnt == WAIT_LIMIT: mem_error<=1 (sticky until reset).
//   - The access continues; wait_cnt saturates.
//  Passthrough: wb_ir, wb_npc, wb_drid always equal the corresponding mem_* inputs.
// TESTING
//  - ADD, mem_valid=1, aluresult=0x1234 -> same cycle: stall=0, wb_valid=1, wb_data=0x1234; no dmem request.
//  - LDR A=0x3001, resp after 3 cycles with rdata=0xBEEF
//    -> dmem_address=0x3000 held 3 cycles; DONE: wb_data=0xBEEF, stall low exactly one cycle later.
//  - STB A=0x4001, srdata=0x00AB -> dmem_write=1, wmask=10, wdata=0xABAB.
//    LDB same address, rdata=0xAB00 -> wb_data=0x00AB.
//  - LDI A=0x5000: pointer read returns 0x6002, final read returns 0x7777
//    -> second request dmem_address=0x6002; wb_data=0x7777.
//  - reset_n=0 during ACC -> dmem_read=0 asynchronously; after release state IDLE, late dmem_resp causes no wb_valid.
//  - WAIT_LIMIT=4, no resp for 10 cycles -> mem_error=1 from 5th wait cycle; still completes on resp.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the pipelined LC-3b.
// Consumes the AGEX->MEM pipeline register and performs data-cache accesses
// (LDR/STR/LDB/STB/LDI/STI) over a request/response handshake. It stalls the
// upstream pipe while an access is in flight and forwards the result to MEM->WB.
// LDI/STI first read a word pointer, then do the final access through it.
//
// Ports
//   clk, reset_n                : clock, asynchronous active-low reset
//   mem_valid/read/write/byte/indirect : decoded control of the MEM-stage instruction
//   mem_address, mem_aluresult  : effective address, ALU/shift result
//   mem_srdata                  : store data
//   mem_ir, mem_npc, mem_drid   : passthrough fields
//   dmem_*                      : data-cache request/response handshake
//   stall_out                   : hold all upstream pipeline registers
//   wb_valid, wb_data           : MEM->WB entry valid and result
//   wb_ir, wb_npc, wb_drid      : passthrough fields
//   mem_error                   : sticky, a single response wait exceeded WAIT_LIMIT
module mem_stage #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_byte,
  input  logic        mem_indirect,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_aluresult,
  input  logic [15:0] mem_srdata,
  input  logic [15:0] mem_ir,
  input  logic [15:0] mem_npc,
  input  logic [2:0]  mem_drid,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output logic [15:0] dmem_wdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [15:0] wb_ir,
  output logic [15:0] wb_npc,
  output logic [2:0]  wb_drid,
  output logic        mem_error
);

  localparam int unsigned CntW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StInd, StAcc, StDone} state_e;

  state_e          state_q, state_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            err_q, err_d;

  logic        op;
  logic [15:0] acc_addr;
  logic [15:0] load_data;
  logic        in_wait;

  assign op       = mem_valid & (mem_read | mem_write);
  assign acc_addr = mem_indirect ? ptr_q : mem_address;
  assign in_wait  = (state_q == StInd) || (state_q == StAcc);

  // Byte loads pick the lane addressed by A[0] and zero-extend it.
  assign load_data = mem_byte ? {8'h00, (acc_addr[0] ? rdata_q[15:8] : rdata_q[7:0])} : rdata_q;

  assign wb_ir     = mem_ir;
  assign wb_npc    = mem_npc;
  assign wb_drid   = mem_drid;
  assign mem_error = err_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    rdata_d      = rdata_q;
    dmem_address = 16'h0000;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 2'b00;
    dmem_wdata   = 16'h0000;
    stall_out    = 1'b0;
    wb_valid     = 1'b0;
    wb_data      = mem_aluresult;
    unique case (state_q)
      StIdle: begin
        if (op) begin
          stall_out = 1'b1;
          state_d   = mem_indirect ? StInd : StAcc;
        end else begin
          wb_valid = mem_valid;
        end
      end
      StInd: begin
        // Pointer fetch is always a word read, regardless of mem_byte.
        stall_out    = 1'b1;
        dmem_read    = 1'b1;
        dmem_address = {mem_address[15:1], 1'b0};
        if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          state_d = StAcc;
        end
      end
      StAcc: begin
        stall_out    = 1'b1;
        dmem_address = {acc_addr[15:1], 1'b0};
        if (mem_read) begin
          dmem_read = 1'b1;
        end else if (mem_write) begin
          dmem_write = 1'b1;
          if (mem_byte) begin
            dmem_wmask = acc_addr[0] ? 2'b10 : 2'b01;
            dmem_wdata = {mem_srdata[7:0], mem_srdata[7:0]};
          end else begin
            dmem_wmask = 2'b11;
            dmem_wdata = mem_srdata;
          end
        end
        if (dmem_resp) begin
          rdata_d = dmem_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        wb_valid = 1'b1;
        wb_data  = mem_read ? load_data : mem_aluresult;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Wait counter restarts on every state entry and saturates at all-ones.
  // The error flag is raised on the edge where the count reaches WAIT_LIMIT,
  // so it is visible in the same cycle that wait_cnt == WAIT_LIMIT.
  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (in_wait && !dmem_resp && !(&wait_q)) begin
      wait_d = wait_q + 1'b1;
    end
    if ((WAIT_LIMIT != 0) && in_wait && !dmem_resp && (wait_d == CntW'(WAIT_LIMIT))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= 16'h0000;
      rdata_q <= 16'h0000;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_read, mem_write, mem_byte, mem_indirect;
  logic [15:0] mem_address, mem_aluresult, mem_srdata, mem_ir, mem_npc;
  logic [2:0]  mem_drid;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] dmem_address, dmem_wdata, wb_data, wb_ir, wb_npc;
  logic        dmem_read, dmem_write, stall_out, wb_valid, mem_error;
  logic [1:0]  dmem_wmask;
  logic [2:0]  wb_drid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mem_valid    (mem_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_byte     (mem_byte),
    .mem_indirect (mem_indirect),
    .mem_address  (mem_address),
    .mem_aluresult(mem_aluresult),
    .mem_srdata   (mem_srdata),
    .mem_ir       (mem_ir),
    .mem_npc      (mem_npc),
    .mem_drid     (mem_drid),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .stall_out    (stall_out),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_ir        (wb_ir),
    .wb_npc       (wb_npc),
    .wb_drid      (wb_drid),
    .mem_error    (mem_error)
  );

  task automatic drive_op(input logic rd, input logic wr, input logic byt, input logic ind,
                          input logic [15:0] addr, input logic [15:0] alu,
                          input logic [15:0] sr);
    mem_valid     = 1'b1;
    mem_read      = rd;
    mem_write     = wr;
    mem_byte      = byt;
    mem_indirect  = ind;
    mem_address   = addr;
    mem_aluresult = alu;
    mem_srdata    = sr;
  endtask

  task automatic drive_idle();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte = 1'b0; mem_indirect = 1'b0;
    dmem_resp = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    mem_address = 16'h0; mem_aluresult = 16'h0; mem_srdata = 16'h0;
    mem_ir = 16'h0; mem_npc = 16'h0; mem_drid = 3'd0; dmem_rdata = 16'h0;
    reset_n = 1'b0;
    #3;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_out); end
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL reset_req got %b%b exp 00", dmem_read, dmem_write); end
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mem_error); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b exp 0", wb_valid); end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_add();
    next_cycle();
    drive_op(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000);
    mem_ir = 16'h1111; mem_npc = 16'h2222; mem_drid = 3'd5;
    @(negedge clk);
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL add_stall got %b exp 0", stall_out); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wbv got %b exp 1", wb_valid); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL add_data got %h exp 1234", wb_data); end
    checks++; if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin errors++; $display("FAIL add_noreq got %b%b exp 00", dmem_read, dmem_write); end
    checks++; if (wb_ir !== 16'h1111 || wb_npc !== 16'h2222 || wb_drid !== 3'd5) begin
      errors++; $display("FAIL add_pass got %h %h %0d exp 1111 2222 5", wb_ir, wb_npc, wb_drid); end
    next_cycle(); drive_idle();
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wbv got %b exp 0", wb_valid); end
  endtask

  task automatic test_ldr();
    next_cycle();
    drive_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h9999, 16'h0000);
    @(negedge clk);
    checks++; if (stall_out !== 1'b1 || wb_valid !== 1'b0 || dmem_read !== 1'b0) begin
      errors++; $display("FAIL ldr_idle got stall=%b wbv=%b rd=%b exp 1 0 0", stall_out, wb_valid, dmem_read); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      dmem_resp  = (i == 2);
      dmem_rdata = (i == 2) ? 16'hBEEF : 16'hDEAD;
      @(negedge clk);
      checks++; if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== 16'h3000 || stall_out !== 1'b1) begin
        errors++; $display("FAIL ldr_acc%0d got rd=%b wr=%b addr=%h stall=%b exp 1 0 3000 1", i, dmem_read, dmem_write, dmem_address, stall_out); end
    end
    next_cycle(); dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    @(negedge clk);
    checks++; if (stall_out !== 1'b0 || wb_valid !== 1'b1 || dmem_read !== 1'b0) begin
      errors++; $display("FAIL ldr_done got stall=%b wbv=%b rd=%b exp 0 1 0", stall_out, wb_valid, dmem_read); end
    checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL ldr_data got %h exp beef", wb_data); end
    next_cycle(); drive_idle();
  endtask

  task automatic test_byte();
    // STB to the odd byte, single-cycle response
    drive_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h4001, 16'h4444, 16'h00AB);
    next_cycle(); dmem_resp = 1'b1;
    @(negedge clk);
    checks++; if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || dmem_wmask !== 2'b10 || dmem_wdata !== 16'hABAB || dmem_address !== 16'h4000) begin
      errors++; $display("FAIL stb_hi got wr=%b rd=%b mask=%b wdata=%h addr=%h exp 1 0 10 abab 4000", dmem_write, dmem_read, dmem_wmask, dmem_wdata, dmem_address); end
    next_cycle(); dmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h4444 || dmem_write !== 1'b0) begin
      errors++; $display("FAIL stb_done got wbv=%b data=%h wr=%b exp 1 4444 0", wb_valid, wb_data, dmem_write); end
    // LDB same address, back-to-back
    next_cycle(); drive_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h4001, 16'h0000, 16'h0000);
    next_cycle(); dmem_resp = 1'b1; dmem_rdata = 16'hAB00;
    @(negedge clk);
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h4000) begin
      errors++; $display("FAIL ldb_req got rd=%b addr=%h exp 1 4000", dmem_read, dmem_address); end
    next_cycle(); dmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (wb_data !== 16'h00AB || wb_valid !== 1'b1) begin
      errors++; $display("FAIL ldb_data got %h wbv=%b exp 00ab 1", wb_data, wb_valid); end
    // Word STR and even-byte STB masks
    next_cycle(); drive_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h4003, 16'h0000, 16'hC3D4);
    next_cycle(); dmem_resp = 1'b1;
    @(negedge clk);
    checks++; if (dmem_wmask !== 2'b11 || dmem_wdata !== 16'hC3D4 || dmem_address !== 16'h4002) begin
      errors++; $display("FAIL str_word got mask=%b wdata=%h addr=%h exp 11 c3d4 4002", dmem_wmask, dmem_wdata, dmem_address); end
    next_cycle(); dmem_resp = 1'b0;
    next_cycle(); drive_op(1'b0, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1234);
    next_cycle(); dmem_resp = 1'b1;
    @(negedge clk);
    checks++; if (dmem_wmask !== 2'b01 || dmem_wdata !== 16'h3434) begin
      errors++; $display("FAIL stb_lo got mask=%b wdata=%h exp 01 3434", dmem_wmask, dmem_wdata); end
    next_cycle(); dmem_resp = 1'b0;
    next_cycle(); drive_idle();
  endtask

  task automatic test_ldi();
    drive_op(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 16'h0000, 16'h0000);
    mem_drid = 3'd2;
    next_cycle();
    @(negedge clk);
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h5000 || stall_out !== 1'b1) begin
      errors++; $display("FAIL ldi_ptr got rd=%b addr=%h stall=%b exp 1 5000 1", dmem_read, dmem_address, stall_out); end
    next_cycle(); dmem_resp = 1'b1; dmem_rdata = 16'h6002;
    @(negedge clk);
    checks++; if (dmem_address !== 16'h5000 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL ldi_ptr_hold got addr=%h wbv=%b exp 5000 0", dmem_address, wb_valid); end
    next_cycle(); dmem_rdata = 16'h7777;
    @(negedge clk);
    checks++; if (dmem_read !== 1'b1 || dmem_address !== 16'h6002) begin
      errors++; $display("FAIL ldi_final_req got rd=%b addr=%h exp 1 6002", dmem_read, dmem_address); end
    next_cycle(); dmem_resp = 1'b0; dmem_rdata = 16'h0000;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h7777 || wb_drid !== 3'd2) begin
      errors++; $display("FAIL ldi_done got wbv=%b data=%h drid=%0d exp 1 7777 2", wb_valid, wb_data, wb_drid); end
    next_cycle(); drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h3001, 16'h0000, 16'h0000);
    next_cycle();
    @(negedge clk);
    checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rst_pre got rd=%b exp 1", dmem_read); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (dmem_read !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_async got rd=%b wbv=%b exp 0 0", dmem_read, wb_valid); end
    next_cycle();
    reset_n = 1'b1; dmem_resp = 1'b1; dmem_rdata = 16'h1111;
    #1;
    checks++; if (dmem_read !== 1'b0 || wb_valid !== 1'b0 || stall_out !== 1'b1) begin
      errors++; $display("FAIL rst_late_resp got rd=%b wbv=%b stall=%b exp 0 0 1", dmem_read, wb_valid, stall_out); end
    next_cycle(); dmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (dmem_read !== 1'b1 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL rst_restart got rd=%b wbv=%b exp 1 0", dmem_read, wb_valid); end
    next_cycle(); dmem_resp = 1'b1; dmem_rdata = 16'h2222;
    next_cycle(); dmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h2222) begin
      errors++; $display("FAIL rst_complete got wbv=%b data=%h exp 1 2222", wb_valid, wb_data); end
    next_cycle(); drive_idle();
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000, 16'h0000);
    @(negedge clk);
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL to_pre got %b exp 0", mem_error); end
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (mem_error !== (i >= 5) || dmem_read !== 1'b1) begin
        errors++; $display("FAIL to_wait%0d got err=%b rd=%b exp %b 1", i, mem_error, dmem_read, (i >= 5)); end
    end
    next_cycle(); dmem_resp = 1'b1; dmem_rdata = 16'h5A5A;
    next_cycle(); dmem_resp = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h5A5A || mem_error !== 1'b1) begin
      errors++; $display("FAIL to_done got wbv=%b data=%h err=%b exp 1 5a5a 1", wb_valid, wb_data, mem_error); end
    next_cycle(); drive_idle();
    @(negedge clk);
    checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_error); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_byte();
    test_ldi();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
